// File: rtl/afu_port_rst_seq.sv
// afu_port_rst_seq: function-level reset sequencer for PF/VF mux ports, one request at a time.
// Optional quiesce timeout is built only when AFU_PORT_RST_TIMEOUT_EN is defined.
module afu_port_rst_seq #(
    parameter int NUM_PORTS      = 4,
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int PW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int CNT_MAX = (RST_CYCLES > TIMEOUT_CYCLES) ? RST_CYCLES : TIMEOUT_CYCLES,
    localparam int CW      = $clog2(CNT_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flr_req_valid,
    output logic                 flr_req_ready,
    input  logic [PW-1:0]        flr_req_port,
    input  logic [NUM_PORTS-1:0] port_idle,
    output logic [NUM_PORTS-1:0] port_block,
    output logic [NUM_PORTS-1:0] port_rst_n,
    output logic                 flr_rsp_valid,
    output logic [PW-1:0]        flr_rsp_port,
    output logic                 flr_rsp_timeout,
    output logic [NUM_PORTS-1:0] timeout_sticky
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_QUIESCE = 3'd1;
    localparam logic [2:0] ST_RESET   = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_RSP     = 3'd4;

    localparam logic [PW:0]   NUM_PORTS_W = (PW + 1)'(NUM_PORTS);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST    = CW'(1);

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic                 live;
    logic [PW-1:0]        port_q;
    logic [CW-1:0]        cnt;
    logic [NUM_PORTS-1:0] sel;
    logic                 target_idle;
    logic                 req_fire;
    logic                 req_oor;
    logic                 cnt_run;
    logic                 holding;

`ifdef AFU_PORT_RST_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic                 timed_out;
    logic [NUM_PORTS-1:0] sticky;
    logic                 quiesce_expired;

    assign quiesce_expired = (state == ST_QUIESCE) && !target_idle && (cnt == TO_LAST);
`endif

    // One-hot view of the latched port; an out-of-range index selects nothing.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sel[i] = (port_q == PW'(i));
        end
    end

    assign target_idle = |(port_idle & sel);
    assign req_fire    = flr_req_valid && flr_req_ready;
    assign req_oor     = ({1'b0, flr_req_port} >= NUM_PORTS_W);
    assign holding     = (state == ST_QUIESCE) || (state == ST_RESET) || (state == ST_RELEASE);

`ifdef AFU_PORT_RST_TIMEOUT_EN
    assign cnt_run = (state == ST_RESET) || (state == ST_RELEASE) || (state == ST_QUIESCE);
`else
    assign cnt_run = (state == ST_RESET) || (state == ST_RELEASE);
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_fire) begin
                    state_next = req_oor ? ST_RSP : ST_QUIESCE;
                end
            end
            ST_QUIESCE: begin
                if (target_idle) begin
                    state_next = ST_RESET;
                end
`ifdef AFU_PORT_RST_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    state_next = ST_RESET;
                end
`endif
            end
            ST_RESET: begin
                if (cnt == RST_LAST) begin
                    state_next = ST_RELEASE;
                end
            end
            // RELEASE lasts two cycles so the response lands RST_CYCLES+4 cycles after acceptance.
            ST_RELEASE: begin
                if (cnt == REL_LAST) begin
                    state_next = ST_RSP;
                end
            end
            ST_RSP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            live   <= 1'b0;
            port_q <= '0;
            cnt    <= '0;
        end else begin
            live  <= 1'b1;
            state <= state_next;
            if (state_next != state) begin
                cnt <= '0;
            end else if (cnt_run) begin
                cnt <= cnt + CW'(1);
            end
            if (req_fire) begin
                port_q <= flr_req_port;
            end
        end
    end

`ifdef AFU_PORT_RST_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timed_out <= 1'b0;
            sticky    <= '0;
        end else begin
            if (req_fire) begin
                timed_out <= 1'b0;
            end else if (quiesce_expired) begin
                timed_out <= 1'b1;
                sticky    <= sticky | sel;
            end
        end
    end

    assign flr_rsp_timeout = (state == ST_RSP) && timed_out;
    assign timeout_sticky  = sticky;
`else
    assign flr_rsp_timeout = 1'b0;
    assign timeout_sticky  = '0;
`endif

    // Until the first edge after reset release every port stays held in reset.
    always_comb begin
        flr_req_ready = live && (state == ST_IDLE);
        port_block    = holding ? sel : '0;
        port_rst_n    = '0;
        if (live) begin
            port_rst_n = (state == ST_RESET) ? ~sel : '1;
        end
        flr_rsp_valid = (state == ST_RSP);
        flr_rsp_port  = (state == ST_RSP) ? port_q : '0;
    end

endmodule

// File: tb/tb_afu_port_rst_seq.sv
// tb_afu_port_rst_seq: directed and randomized stimulus against a cycle-timeline model of
// the FLR sequence; literal checks pin the model on the documented scenarios.
module tb_afu_port_rst_seq;

    localparam int NP   = 5;
    localparam int PWT  = 3;
    localparam int RSTC = 16;
    localparam int TOC  = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flr_req_valid = 1'b0;
    logic           flr_req_ready;
    logic [PWT-1:0] flr_req_port = '0;
    logic [NP-1:0]  port_idle = '1;
    logic [NP-1:0]  port_block;
    logic [NP-1:0]  port_rst_n;
    logic           flr_rsp_valid;
    logic [PWT-1:0] flr_rsp_port;
    logic           flr_rsp_timeout;
    logic [NP-1:0]  timeout_sticky;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: one transaction described by its acceptance cycle and the cycle quiesce ended.
    logic          m_busy   = 1'b0;
    logic          m_live   = 1'b0;
    logic          m_oor    = 1'b0;
    logic          m_tmo    = 1'b0;
    logic [NP-1:0] m_sticky = '0;
    int            m_p      = 0;
    int            m_t      = 0;
    int            m_qend   = -1;

    afu_port_rst_seq #(
        .NUM_PORTS(NP),
        .RST_CYCLES(RSTC),
        .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flr_req_valid(flr_req_valid),
        .flr_req_ready(flr_req_ready),
        .flr_req_port(flr_req_port),
        .port_idle(port_idle),
        .port_block(port_block),
        .port_rst_n(port_rst_n),
        .flr_rsp_valid(flr_rsp_valid),
        .flr_rsp_port(flr_rsp_port),
        .flr_rsp_timeout(flr_rsp_timeout),
        .timeout_sticky(timeout_sticky)
    );

    always #5 clk = ~clk;

    function automatic int rspCycle();
        return m_oor ? (m_t + 1) : (m_qend + RSTC + 3);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic runTo(input int target);
        while (cyc < target) nextCycle();
    endtask

    task automatic applyStimulus(input logic valid, input logic [PWT-1:0] port, input logic [NP-1:0] idle);
        flr_req_valid = valid;
        flr_req_port  = port;
        port_idle     = idle;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_busy   <= 1'b0;
            m_live   <= 1'b0;
            m_oor    <= 1'b0;
            m_tmo    <= 1'b0;
            m_sticky <= '0;
            m_qend   <= -1;
        end else begin
            m_live <= 1'b1;
            if (m_busy) begin
                if (!m_oor && m_qend < 0) begin
                    if (port_idle[m_p]) begin
                        m_qend <= cyc;
                    end
`ifdef AFU_PORT_RST_TIMEOUT_EN
                    else if (cyc - m_t == TOC) begin
                        m_qend        <= cyc;
                        m_tmo         <= 1'b1;
                        m_sticky[m_p] <= 1'b1;
                    end
`endif
                end else if (cyc == rspCycle()) begin
                    m_busy <= 1'b0;
                end
            end else if (m_live && flr_req_valid) begin
                m_busy <= 1'b1;
                m_t    <= cyc;
                m_p    <= int'(flr_req_port);
                m_oor  <= (flr_req_port >= PWT'(NP));
                m_qend <= -1;
                m_tmo  <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin : compare
        logic [NP-1:0] e_block;
        logic [NP-1:0] e_rstn;
        logic          e_ready;
        logic          e_valid;
        logic          e_tmo;
        if (rst) begin
            e_ready = 1'b0;
            e_block = '0;
            e_rstn  = '0;
            e_valid = 1'b0;
            e_tmo   = 1'b0;
        end else begin
            e_ready = m_live && !m_busy;
            e_block = '0;
            e_rstn  = m_live ? '1 : '0;
            e_valid = m_busy && (m_oor || m_qend >= 0) && (cyc == rspCycle());
            e_tmo   = e_valid && m_tmo;
            if (m_busy && !m_oor && !e_valid) e_block[m_p] = 1'b1;
            if (m_busy && !m_oor && m_qend >= 0 && cyc > m_qend && cyc <= m_qend + RSTC) e_rstn[m_p] = 1'b0;
        end
        checkOutput("flr_req_ready", 32'(flr_req_ready), 32'(e_ready));
        checkOutput("port_block", 32'(port_block), 32'(e_block));
        checkOutput("port_rst_n", 32'(port_rst_n), 32'(e_rstn));
        checkOutput("flr_rsp_valid", 32'(flr_rsp_valid), 32'(e_valid));
        checkOutput("flr_rsp_timeout", 32'(flr_rsp_timeout), 32'(e_tmo));
        checkOutput("timeout_sticky", 32'(timeout_sticky), rst ? 32'd0 : 32'(m_sticky));
        if (rst || e_valid) checkOutput("flr_rsp_port", 32'(flr_rsp_port), rst ? 32'd0 : 32'(m_p));
    end

    initial begin
        int t;
        int rsp_seen;
        repeat (3) nextCycle();

        // Reset release: ports stay in reset until the first edge afterwards.
        rst = 1'b0;
        #1;
        checkOutput("lit_rst_n_before_edge", 32'(port_rst_n), 32'h0);
        nextCycle();
        checkOutput("lit_ready_after_release", 32'(flr_req_ready), 32'h1);
        checkOutput("lit_rst_n_after_release", 32'(port_rst_n), 32'h1f);

        // Idle port 2: reset pulse T+2..T+17, response at T+20.
        applyStimulus(1'b1, 3'd2, 5'b11111);
        t = cyc;
        nextCycle();
        applyStimulus(1'b0, 3'd0, 5'b11111);
        runTo(t + 2);
        checkOutput("lit_p2_rst_first", 32'(port_rst_n), 32'h1b);
        runTo(t + 17);
        checkOutput("lit_p2_rst_last", 32'(port_rst_n), 32'h1b);
        runTo(t + 18);
        checkOutput("lit_p2_released", 32'(port_rst_n), 32'h1f);
        checkOutput("lit_p2_block", 32'(port_block), 32'h04);
        runTo(t + 19);
        checkOutput("lit_p2_no_rsp_yet", 32'(flr_rsp_valid), 32'h0);
        runTo(t + 20);
        checkOutput("lit_p2_rsp", 32'(flr_rsp_valid), 32'h1);
        checkOutput("lit_p2_rsp_port", 32'(flr_rsp_port), 32'h2);
        checkOutput("lit_p2_rsp_tmo", 32'(flr_rsp_timeout), 32'h0);

        // Port 1 busy for 50 cycles while other ports toggle idle.
        nextCycle();
        applyStimulus(1'b1, 3'd1, 5'b11101);
        t = cyc;
        nextCycle();
        flr_req_valid = 1'b0;
        while (cyc < t + 50) begin
            port_idle = NP'($urandom) & 5'b11101;
            nextCycle();
        end
        checkOutput("lit_p1_block_wait", 32'(port_block), 32'h02);
        checkOutput("lit_p1_rst_n_wait", 32'(port_rst_n), 32'h1f);
        runTo(t + 51);
        port_idle = 5'b11111;
        runTo(t + 52);
        checkOutput("lit_p1_rst", 32'(port_rst_n), 32'h1d);
        runTo(t + 70);
        checkOutput("lit_p1_rsp", 32'(flr_rsp_valid), 32'h1);
        checkOutput("lit_p1_rsp_port", 32'(flr_rsp_port), 32'h1);

        // Port 3 never idle on its own.
        nextCycle();
        applyStimulus(1'b1, 3'd3, 5'b10111);
        t = cyc;
        nextCycle();
        flr_req_valid = 1'b0;
`ifdef AFU_PORT_RST_TIMEOUT_EN
        runTo(t + 8);
        checkOutput("lit_p3_quiesce_end", 32'(port_rst_n), 32'h1f);
        runTo(t + 9);
        checkOutput("lit_p3_rst_after_timeout", 32'(port_rst_n), 32'h17);
        checkOutput("lit_p3_sticky", 32'(timeout_sticky), 32'h08);
        runTo(t + 27);
        checkOutput("lit_p3_rsp", 32'(flr_rsp_valid), 32'h1);
        checkOutput("lit_p3_rsp_tmo", 32'(flr_rsp_timeout), 32'h1);
        port_idle = 5'b11111;
        runTo(t + 28);
        checkOutput("lit_p3_sticky_kept", 32'(timeout_sticky), 32'h08);
`else
        runTo(t + 30);
        checkOutput("lit_p3_still_blocked", 32'(port_block), 32'h08);
        checkOutput("lit_p3_no_reset", 32'(port_rst_n), 32'h1f);
        checkOutput("lit_p3_sticky_zero", 32'(timeout_sticky), 32'h0);
        runTo(t + 31);
        port_idle = 5'b11111;
        runTo(t + 50);
        checkOutput("lit_p3_rsp", 32'(flr_rsp_valid), 32'h1);
        checkOutput("lit_p3_rsp_tmo", 32'(flr_rsp_timeout), 32'h0);
`endif

        // Out-of-range port 5: immediate response, no port touched.
        nextCycle();
        applyStimulus(1'b1, 3'd5, 5'b11111);
        t = cyc;
        nextCycle();
        flr_req_valid = 1'b0;
        checkOutput("lit_p5_rsp", 32'(flr_rsp_valid), 32'h1);
        checkOutput("lit_p5_rsp_port", 32'(flr_rsp_port), 32'h5);
        checkOutput("lit_p5_block", 32'(port_block), 32'h0);
        checkOutput("lit_p5_rst_n", 32'(port_rst_n), 32'h1f);
        runTo(t + 2);
        checkOutput("lit_p5_ready_again", 32'(flr_req_ready), 32'h1);

        // Back-to-back: second request accepted the cycle after the first response.
        applyStimulus(1'b1, 3'd4, 5'b11111);
        t = cyc;
        runTo(t + 20);
        checkOutput("lit_b2b_rsp", 32'(flr_rsp_valid), 32'h1);
        checkOutput("lit_b2b_busy", 32'(flr_req_ready), 32'h0);
        runTo(t + 21);
        checkOutput("lit_b2b_ready", 32'(flr_req_ready), 32'h1);
        runTo(t + 22);
        flr_req_valid = 1'b0;
        checkOutput("lit_b2b_second_block", 32'(port_block), 32'h10);
        runTo(t + 45);

        // Reset during RESET of port 0 abandons the request.
        applyStimulus(1'b1, 3'd0, 5'b11111);
        t = cyc;
        nextCycle();
        flr_req_valid = 1'b0;
        runTo(t + 5);
        rst = 1'b1;
        #1;
        checkOutput("lit_mid_rst_ready", 32'(flr_req_ready), 32'h0);
        checkOutput("lit_mid_rst_block", 32'(port_block), 32'h0);
        checkOutput("lit_mid_rst_rst_n", 32'(port_rst_n), 32'h0);
        checkOutput("lit_mid_rst_sticky", 32'(timeout_sticky), 32'h0);
        runTo(t + 7);
        rst = 1'b0;
        rsp_seen = 0;
        repeat (30) begin
            nextCycle();
            rsp_seen += int'(flr_rsp_valid);
        end
        checkOutput("lit_no_rsp_after_abort", 32'(rsp_seen), 32'h0);

        // Random traffic: first mostly-idle ports, then frequently busy ones.
        for (int i = 0; i < 3000; i++) begin
            nextCycle();
            flr_req_valid = ($urandom_range(0, 3) != 0);
            flr_req_port  = PWT'($urandom_range(0, 7));
            if (i < 1500) port_idle = ~(NP'($urandom) & NP'($urandom) & NP'($urandom));
            else          port_idle = NP'($urandom);
            rst = ($urandom_range(0, 499) == 0);
        end
        rst = 1'b0;
        flr_req_valid = 1'b0;
        repeat (5) nextCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
